img_pingpong_buffer: RTL and testbench
======================================

Name: img_pingpong_buffer

Overview:
- Parametrised double-banked (ping-pong) image buffer between the byte-stream receiver and the BNN inference core.
- Packs a stream of BUS_W-bit words into a flat image vector.
- While the core consumes one bank, the next frame loads into the other.
- Adds a ready/valid write handshake, an early frame terminator, consumer release handshake, and overflow reporting.

Parameters:
- IMG_W, 30, image width in pixels (1 bit/pixel).
- IMG_H, 30, image height in pixels.
- BUS_W, 8, write word width in bits; must be ≥1.
- Derived localparams:
  - NWORDS = ceil(IMG_W*IMG_H/BUS_W) (default 113).
  - TOTAL_BITS = NWORDS*BUS_W (default 904).
  - CW = $clog2(NWORDS+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of both banks and all state
- wr_data  in  BUS_W  write word
- wr_valid  in  1  write word present
- wr_last  in  1  with wr_valid: final word of frame (early close allowed)
- wr_ready  out  1  write bank can accept a word
- wr_count  out  CW  words written into current write bank
- img_valid  out  1  read bank holds a complete frame
- img_ready  in  1  consumer releases read bank
- img_out  out  TOTAL_BITS  read bank contents
- overflow_err  out  1  sticky: wr_valid seen while wr_ready low
- frame_cnt  out  16  completed frames (see Optional Feature)
- drop_cnt  out  16  rejected words (see Optional Feature)

Behaviour:
- Banks and state:
  - Two banks, B0/B1, each TOTAL_BITS wide, each with state FREE or FULL.
  - Registers wr_bank and rd_bank (1 bit each) and wr_ptr (CW bits).
- Reset (rst_n low, async):
  - Both banks zeroed and FREE; wr_bank=rd_bank=0; wr_ptr=0.
  - Outputs: wr_ready=1, wr_count=0, img_valid=0, img_out=0, overflow_err=0, frame_cnt=0, drop_cnt=0.
- clear (sync):
  - Same effect as reset on the next edge.
  - Overrides any write or release in the same cycle.
- Combinational outputs:
  - wr_ready = (state[wr_bank]==FREE).
  - img_valid = (state[rd_bank]==FULL).
  - img_out = data[rd_bank], stable while img_valid is high.
  - wr_count = wr_ptr.
- Write accept (wr_valid && wr_ready):
  - data[wr_bank][wr_ptr*BUS_W +: BUS_W] <= wr_data; word 0 occupies the LSBs.
  - Frame closes if wr_last or wr_ptr==NWORDS-1.
    - On close: state[wr_bank]<=FULL, wr_bank toggles, wr_ptr<=0, frame_cnt++.
    - Otherwise: wr_ptr++.
  - Early close leaves the unwritten words zero.
- Latency: img_valid rises in the cycle after the accepting edge of the closing word, provided that bank is rd_bank.
- Release (img_valid && img_ready):
  - state[rd_bank]<=FREE, data[rd_bank]<=0, rd_bank toggles.
  - img_ready while img_valid is low is ignored.
- Rejected write (wr_valid && !wr_ready):
  - Word dropped, overflow_err<=1 (sticky until reset/clear), drop_cnt++.
  - State and pointers unchanged.
- Simultaneous close and release in one cycle: both take effect.
  - Different banks: independent updates.
  - Same bank is impossible, since a closing bank is FREE and a releasing bank is FULL.
- Both banks FULL: wr_ready=0 until the next release.
- wr_ready rises in the cycle after the releasing edge; no combinational path from img_ready to wr_ready.
- Counters saturate at 16'hFFFF.
- wr_ptr never exceeds NWORDS-1 while a bank is FREE.
- Reset mid-frame: the partial frame is discarded; no frame_cnt increment.

Optional Feature:
- Macro: IMG_BUF_STATS_EN.
- Defined: frame_cnt and drop_cnt behave as specified.
- Undefined:
  - Both ports are tied to 16'd0 and their counter registers are not built.
  - overflow_err and all other behaviour are unchanged.

Test Plan:
- Single frame: after reset, send 113 words with 8'hA5 at word 0 and 8'h3C at word 112 (wr_last=0 throughout) -> img_valid=1 next cycle, img_out[7:0]=A5, img_out[903:896]=3C, wr_ready=1, wr_count=0, frame_cnt=1.
- Ping-pong: fill two frames without releasing -> wr_ready=0; a 227th word is dropped, overflow_err=1, drop_cnt=1; pulse img_ready -> img_out shows frame 2, wr_ready=1 the next cycle.
- Early close: 5 words 8'hFF with wr_last on word 5 -> img_out[39:0]=all ones, img_out[903:40]=0, img_valid=1.
- Simultaneous: assert the closing word of frame 2 in the same cycle as img_ready for frame 1 -> next cycle img_valid=1 showing frame 2, wr_bank=0 FREE, no drop.
- clear mid-frame: after 50 words, assert clear together with wr_valid -> wr_count=0, img_valid=0, overflow_err=0, the concurrent word is not stored; async rst_n mid-frame gives the same result.
- Non-default BUS_W=32, IMG_W=IMG_H=30: NWORDS=29, TOTAL_BITS=928; 29 words close the frame, the upper 28 bits of word 28 hold wr_data[31:4] as written.

Source files
------------

// File: rtl/img_pingpong_buffer.sv
// Two-bank (ping-pong) image buffer: packs BUS_W-bit words into a flat frame while the other bank is consumed.
// Define IMG_BUF_STATS_EN to build the frame_cnt/drop_cnt counters; otherwise both ports read zero.
module img_pingpong_buffer #(
  parameter int IMG_W = 30,
  parameter int IMG_H = 30,
  parameter int BUS_W = 8,
  localparam int NWORDS = (IMG_W * IMG_H + BUS_W - 1) / BUS_W,
  localparam int TOTAL_BITS = NWORDS * BUS_W,
  localparam int CW = $clog2(NWORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [BUS_W-1:0]      wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic [CW-1:0]         wr_count,
  output logic                  img_valid,
  input  logic                  img_ready,
  output logic [TOTAL_BITS-1:0] img_out,
  output logic                  overflow_err,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  logic [TOTAL_BITS-1:0] bank_data [2];
  logic [1:0]            bank_full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [CW-1:0]         wr_ptr;

  logic wr_accept;
  logic wr_reject;
  logic wr_close;
  logic rd_release;

  // Handshakes: a word transfers on a clock edge where wr_valid && wr_ready; a frame is
  // released on an edge where img_valid && img_ready. Ready/valid only depend on registered state.
  assign wr_ready   = ~bank_full[wr_bank];
  assign img_valid  = bank_full[rd_bank];
  assign img_out    = bank_data[rd_bank];
  assign wr_count   = wr_ptr;

  assign wr_accept  = wr_valid && wr_ready;
  assign wr_reject  = wr_valid && !wr_ready;
  assign wr_close   = wr_accept && (wr_last || (wr_ptr == CW'(NWORDS - 1)));
  assign rd_release = img_valid && img_ready;

  // A bank being released is FULL and a bank being written is FREE, so the two never collide.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bank_data[b] <= '0;
      end else if (clear) begin
        bank_data[b] <= '0;
      end else if (rd_release && (rd_bank == 1'(b))) begin
        bank_data[b] <= '0;
      end else if (wr_accept && (wr_bank == 1'(b))) begin
        for (int w = 0; w < NWORDS; w++) begin
          if (wr_ptr == CW'(w)) begin
            bank_data[b][w*BUS_W +: BUS_W] <= wr_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full    <= 2'b00;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_ptr       <= '0;
      overflow_err <= 1'b0;
    end else if (clear) begin
      bank_full    <= 2'b00;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_ptr       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_close ? '0 : wr_ptr + CW'(1);
      end
      if (wr_close) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank            <= ~wr_bank;
      end
      if (rd_release) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
      if (wr_reject) begin
        overflow_err <= 1'b1;
      end
    end
  end

`ifdef IMG_BUF_STATS_EN
  logic [15:0] frame_q;
  logic [15:0] drop_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      drop_q  <= '0;
    end else if (clear) begin
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      if (wr_close && (frame_q != 16'hFFFF)) begin
        frame_q <= frame_q + 16'd1;
      end
      if (wr_reject && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_q;
  assign drop_cnt  = drop_q;
`else
  assign frame_cnt = 16'd0;
  assign drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_img_pingpong_buffer.sv
// Directed bench for img_pingpong_buffer: default 30x30/8-bit instance plus a 32-bit bus instance.
// Counter expectations follow IMG_BUF_STATS_EN (zero when the counters are not built).
module tb_img_pingpong_buffer;

`ifdef IMG_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance: NWORDS=113, TOTAL_BITS=904, CW=7
  logic         clear, wr_valid, wr_last, img_ready;
  logic [7:0]   wr_data;
  logic         wr_ready, img_valid, overflow_err;
  logic [6:0]   wr_count;
  logic [903:0] img_out;
  logic [15:0]  frame_cnt, drop_cnt;

  // 32-bit bus instance: NWORDS=29, TOTAL_BITS=928, CW=5
  logic         clear32, wr_valid32, wr_last32, img_ready32;
  logic [31:0]  wr_data32;
  logic         wr_ready32, img_valid32, overflow_err32;
  logic [4:0]   wr_count32;
  logic [927:0] img_out32;
  logic [15:0]  frame_cnt32, drop_cnt32;

  img_pingpong_buffer #(.IMG_W(30), .IMG_H(30), .BUS_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last),
    .wr_ready(wr_ready), .wr_count(wr_count),
    .img_valid(img_valid), .img_ready(img_ready), .img_out(img_out),
    .overflow_err(overflow_err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  img_pingpong_buffer #(.IMG_W(30), .IMG_H(30), .BUS_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .clear(clear32),
    .wr_data(wr_data32), .wr_valid(wr_valid32), .wr_last(wr_last32),
    .wr_ready(wr_ready32), .wr_count(wr_count32),
    .img_valid(img_valid32), .img_ready(img_ready32), .img_out(img_out32),
    .overflow_err(overflow_err32), .frame_cnt(frame_cnt32), .drop_cnt(drop_cnt32)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [1023:0] exp_q[$];
  logic [7:0]    fw   [128];
  logic [31:0]   fw32 [29];
  logic [1023:0] e32;
  logic [1023:0] zero_img;

  function automatic logic [63:0] sc(input int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input logic [1023:0] obs, input logic [1023:0] exp,
                         input int bits);
    for (int k = 0; k < (bits + 63) / 64; k++) begin
      chk($sformatf("%s[%0d]", tag, k), obs[k*64 +: 64], exp[k*64 +: 64]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Sends fw[0..n-1]; wr_last on the final word if use_last; img_ready on the final word if rel_last.
  task automatic send8(input int n, input bit use_last, input bit rel_last);
    logic [1023:0] e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      wr_data   = fw[i];
      wr_valid  = 1'b1;
      wr_last   = use_last && (i == n - 1);
      img_ready = rel_last && (i == n - 1);
      e[i*8 +: 8] = fw[i];
      tick();
    end
    wr_valid  = 1'b0;
    wr_last   = 1'b0;
    img_ready = 1'b0;
    if (rel_last) void'(exp_q.pop_front());
    if (use_last || n == 113) exp_q.push_back(e);
  endtask

  task automatic release_frame();
    img_ready = 1'b1;
    tick();
    img_ready = 1'b0;
    void'(exp_q.pop_front());
  endtask

  initial begin
    zero_img = '0;
    clear = 0; wr_valid = 0; wr_last = 0; img_ready = 0; wr_data = '0;
    clear32 = 0; wr_valid32 = 0; wr_last32 = 0; img_ready32 = 0; wr_data32 = '0;

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    chk("rst_img_valid", 64'(img_valid), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk_img("rst_img_out", 1024'(img_out), zero_img, 904);
    rst_n = 1'b1;
    tick();

    // 32-bit bus: 29 words close the frame without wr_last
    e32 = '0;
    for (int i = 0; i < 29; i++) fw32[i] = $urandom_range(32'hFFFF_FFFF, 0);
    fw32[28] = 32'hDEADBEEF;
    for (int i = 0; i < 29; i++) begin
      wr_data32  = fw32[i];
      wr_valid32 = 1'b1;
      e32[i*32 +: 32] = fw32[i];
      tick();
      if (i == 27) begin
        chk("b32_count28", 64'(wr_count32), 64'd28);
        chk("b32_not_valid", 64'(img_valid32), 64'd0);
      end
    end
    wr_valid32 = 1'b0;
    chk("b32_img_valid", 64'(img_valid32), 64'd1);
    chk("b32_wr_count", 64'(wr_count32), 64'd0);
    chk("b32_top28", 64'(img_out32[927:900]), 64'h0DEADBEE);
    chk_img("b32_img", 1024'(img_out32), e32, 928);

    // single frame, no wr_last
    for (int i = 0; i < 113; i++) fw[i] = 8'($urandom_range(255, 0));
    fw[0] = 8'hA5; fw[112] = 8'h3C;
    send8(113, 1'b0, 1'b0);
    chk("f1_img_valid", 64'(img_valid), 64'd1);
    chk("f1_lsb", 64'(img_out[7:0]), 64'hA5);
    chk("f1_msb", 64'(img_out[903:896]), 64'h3C);
    chk("f1_wr_ready", 64'(wr_ready), 64'd1);
    chk("f1_wr_count", 64'(wr_count), 64'd0);
    chk("f1_frame_cnt", 64'(frame_cnt), sc(1));
    chk_img("f1_img", 1024'(img_out), exp_q[0], 904);

    // second frame fills the other bank; both full
    for (int i = 0; i < 113; i++) fw[i] = 8'(i * 3 + 1);
    send8(113, 1'b0, 1'b0);
    chk("pp_wr_ready", 64'(wr_ready), 64'd0);
    chk("pp_frame_cnt", 64'(frame_cnt), sc(2));
    wr_data = 8'h99; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("pp_overflow", 64'(overflow_err), 64'd1);
    chk("pp_drop_cnt", 64'(drop_cnt), sc(1));
    chk("pp_wr_count", 64'(wr_count), 64'd0);
    chk_img("pp_still_f1", 1024'(img_out), exp_q[0], 904);
    img_ready = 1'b1;
    #1;
    chk("pp_no_comb_ready", 64'(wr_ready), 64'd0);
    release_frame();
    chk("pp_rel_wr_ready", 64'(wr_ready), 64'd1);
    chk("pp_rel_valid", 64'(img_valid), 64'd1);
    chk_img("pp_f2", 1024'(img_out), exp_q[0], 904);

    // simultaneous close (early, 3 words) and release of the previous frame
    fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33;
    send8(3, 1'b1, 1'b1);
    chk("sim_valid", 64'(img_valid), 64'd1);
    chk("sim_wr_ready", 64'(wr_ready), 64'd1);
    chk("sim_drop_cnt", 64'(drop_cnt), sc(1));
    chk("sim_frame_cnt", 64'(frame_cnt), sc(3));
    chk("sim_lsb24", 64'(img_out[23:0]), 64'h332211);
    chk_img("sim_img", 1024'(img_out), exp_q[0], 904);
    release_frame();
    chk("rel_valid", 64'(img_valid), 64'd0);
    chk_img("rel_zero", 1024'(img_out), zero_img, 904);

    // early close: five 0xFF words
    for (int i = 0; i < 5; i++) fw[i] = 8'hFF;
    send8(5, 1'b1, 1'b0);
    chk("ec_valid", 64'(img_valid), 64'd1);
    chk("ec_low40", 64'(img_out[39:0]), 64'hFF_FFFF_FFFF);
    chk("ec_frame_cnt", 64'(frame_cnt), sc(4));
    chk_img("ec_img", 1024'(img_out), exp_q[0], 904);
    release_frame();

    // clear mid-frame with a concurrent write
    for (int i = 0; i < 50; i++) fw[i] = 8'(i + 8'h40);
    send8(50, 1'b0, 1'b0);
    chk("clr_pre_count", 64'(wr_count), 64'd50);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    chk("clr_wr_count", 64'(wr_count), 64'd0);
    chk("clr_valid", 64'(img_valid), 64'd0);
    chk("clr_overflow", 64'(overflow_err), 64'd0);
    chk("clr_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("clr_wr_ready", 64'(wr_ready), 64'd1);
    fw[0] = 8'h5E;
    send8(1, 1'b1, 1'b0);
    chk("clr_after_cnt", 64'(frame_cnt), sc(1));
    chk_img("clr_after_img", 1024'(img_out), exp_q[0], 904);
    release_frame();

    // asynchronous reset mid-frame
    for (int i = 0; i < 20; i++) fw[i] = 8'(8'hC0 ^ i);
    send8(20, 1'b0, 1'b0);
    chk("ar_pre_count", 64'(wr_count), 64'd20);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wr_count", 64'(wr_count), 64'd0);
    chk("ar_valid", 64'(img_valid), 64'd0);
    chk("ar_wr_ready", 64'(wr_ready), 64'd1);
    chk("ar_frame_cnt", 64'(frame_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    fw[0] = 8'h81;
    send8(1, 1'b1, 1'b0);
    chk("ar_after_cnt", 64'(frame_cnt), sc(1));
    chk_img("ar_after_img", 1024'(img_out), exp_q[0], 904);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
